// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } tts_state_t;

    localparam int unsigned TTS_N_IN_MIN = 1;
    localparam int unsigned TTS_N_IN_MAX = 6;

    function automatic int unsigned tts_depth(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/tts_mux.sv
// Parametrised 2**N_SEL:1 bit selector: picks one truth-table entry by index.
module tts_mux
    import tts_pkg::*;
#(
    parameter  int unsigned N_SEL = 2,
    localparam int unsigned DEPTH = tts_depth(N_SEL)
) (
    input  logic [DEPTH-1:0] tbl_i,
    input  logic [N_SEL-1:0] sel_i,
    output logic             bit_c
);

    assign bit_c = tbl_i[sel_i];

endmodule

// File: rtl/truth_table_sweeper.sv
// Programmable N-input boolean function: registered lookup plus full minterm sweep.
// Optional TTS_CHECK_EN adds an expected table and a mismatch counter.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter  int unsigned N_IN = 2,
    localparam int unsigned TT_D = tts_depth(N_IN),
    localparam int unsigned CW   = N_IN + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tt_load,
    input  logic [TT_D-1:0] tt_in,
    input  logic [N_IN-1:0] eval_x,
    output logic            eval_s,
    input  logic            start,
    output logic            busy,
    output logic            sweep_valid,
    output logic [N_IN-1:0] sweep_m,
    output logic            sweep_s,
    output logic [CW-1:0]   ones_cnt,
    output logic            done
`ifdef TTS_CHECK_EN
    ,
    input  logic [TT_D-1:0] exp_in,
    output logic [CW-1:0]   mism_cnt
`endif
);

    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TT_D - 1);

    tts_state_t      state_q, state_d;
    logic [TT_D-1:0] table_q, table_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [CW-1:0]   ones_q, ones_d;
    logic            eval_s_q, eval_s_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [N_IN-1:0] m_q, m_d;
    logic            s_q, s_d;
    logic            done_q, done_d;
    logic            eval_bit_c;
    logic            sweep_bit_c;
    logic            idle_free_c;

`ifdef TTS_CHECK_EN
    logic [TT_D-1:0] exp_q, exp_d;
    logic [CW-1:0]   mism_q, mism_d;
    logic            mism_bit_c;

    assign mism_bit_c = sweep_bit_c ^ exp_q[idx_q];
`endif

    tts_mux #(.N_SEL(N_IN)) u_eval_mux (
        .tbl_i (table_q),
        .sel_i (eval_x),
        .bit_c (eval_bit_c)
    );

    tts_mux #(.N_SEL(N_IN)) u_sweep_mux (
        .tbl_i (table_q),
        .sel_i (idx_q),
        .bit_c (sweep_bit_c)
    );

    // The DONE cycle is still busy on the outputs, so IDLE only accepts commands once busy drops.
    assign idle_free_c = (state_q == IDLE) && !busy_q;

    always_comb begin
        state_d  = state_q;
        table_d  = table_q;
        idx_d    = idx_q;
        ones_d   = ones_q;
        eval_s_d = eval_bit_c;
        busy_d   = 1'b0;
        valid_d  = 1'b0;
        m_d      = '0;
        s_d      = 1'b0;
        done_d   = 1'b0;
`ifdef TTS_CHECK_EN
        exp_d    = exp_q;
        mism_d   = mism_q;
`endif

        case (state_q)
            IDLE: begin
                if (idle_free_c) begin
                    if (tt_load) begin
                        table_d = tt_in;
`ifdef TTS_CHECK_EN
                        exp_d   = exp_in;
`endif
                    end
                    if (start) begin
                        state_d = SWEEP;
                        idx_d   = '0;
                        ones_d  = '0;
`ifdef TTS_CHECK_EN
                        mism_d  = '0;
`endif
                    end
                end
            end
            SWEEP: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                m_d     = idx_q;
                s_d     = sweep_bit_c;
                ones_d  = ones_q + CW'(sweep_bit_c);
`ifdef TTS_CHECK_EN
                mism_d  = mism_q + CW'(mism_bit_c);
`endif
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + N_IN'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            table_q  <= '0;
            idx_q    <= '0;
            ones_q   <= '0;
            eval_s_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            m_q      <= '0;
            s_q      <= 1'b0;
            done_q   <= 1'b0;
`ifdef TTS_CHECK_EN
            exp_q    <= '0;
            mism_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            table_q  <= table_d;
            idx_q    <= idx_d;
            ones_q   <= ones_d;
            eval_s_q <= eval_s_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            m_q      <= m_d;
            s_q      <= s_d;
            done_q   <= done_d;
`ifdef TTS_CHECK_EN
            exp_q    <= exp_d;
            mism_q   <= mism_d;
`endif
        end
    end

    assign eval_s      = eval_s_q;
    assign busy        = busy_q;
    assign sweep_valid = valid_q;
    assign sweep_m     = m_q;
    assign sweep_s     = s_q;
    assign ones_cnt    = ones_q;
    assign done        = done_q;
`ifdef TTS_CHECK_EN
    assign mism_cnt    = mism_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: directed and random tables on N_IN=2 and N_IN=3 instances.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start2, load2, start3, load3;
    logic [7:0] tt_in, exp_in;
    logic [2:0] eval_x;

    logic       e2, b2, v2, s2, d2;
    logic [1:0] m2;
    logic [2:0] o2, mm2;
    logic       e3, b3, v3, s3, d3;
    logic [2:0] m3;
    logic [3:0] o3, mm3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tt_load(load2), .tt_in(tt_in[3:0]),
        .eval_x(eval_x[1:0]), .eval_s(e2), .start(start2), .busy(b2),
        .sweep_valid(v2), .sweep_m(m2), .sweep_s(s2), .ones_cnt(o2), .done(d2)
`ifdef TTS_CHECK_EN
        , .exp_in(exp_in[3:0]), .mism_cnt(mm2)
`endif
    );

    truth_table_sweeper #(.N_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .tt_load(load3), .tt_in(tt_in),
        .eval_x(eval_x), .eval_s(e3), .start(start3), .busy(b3),
        .sweep_valid(v3), .sweep_m(m3), .sweep_s(s3), .ones_cnt(o3), .done(d3)
`ifdef TTS_CHECK_EN
        , .exp_in(exp_in), .mism_cnt(mm3)
`endif
    );

`ifndef TTS_CHECK_EN
    assign mm2 = '0;
    assign mm3 = '0;
`endif

    // Observation view of whichever instance is under test.
    bit         use3;
    logic       ov, os, ob, od, oe;
    logic [2:0] om;
    logic [3:0] oo, omm;
    always_comb begin
        if (use3) begin
            ov = v3; os = s3; ob = b3; od = d3; oe = e3; om = m3; oo = o3; omm = mm3;
        end else begin
            ov = v2; os = s2; ob = b2; od = d2; oe = e2;
            om = {1'b0, m2}; oo = {1'b0, o2}; omm = {1'b0, mm2};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        use3 = 1'b0; #0;
        chk({tag, "_2"}, {ov, os, ob, od, oe, om, oo, omm}, 32'd0);
        use3 = 1'b1; #0;
        chk({tag, "_3"}, {ov, os, ob, od, oe, om, oo, omm}, 32'd0);
    endtask

    task automatic load(input bit sel3, input logic [7:0] tbl, input logic [7:0] ex);
        tt_in = tbl; exp_in = ex;
        if (sel3) load3 = 1'b1; else load2 = 1'b1;
        step();
        load2 = 1'b0; load3 = 1'b0;
    endtask

    task automatic eval_chk(input bit sel3, input logic [7:0] tbl, input logic [2:0] x);
        use3 = sel3;
        eval_x = x;
        step();
        chk("eval_s", 32'(oe), 32'(tbl[x]));
    endtask

    // Run one full sweep; optionally load with the start edge and inject ignored commands mid-sweep.
    task automatic sweep(input bit sel3, input logic [7:0] tbl, input logic [7:0] ex,
                         input int inject_at, input bit with_load);
        int depth;
        int exp_ones;
        int exp_mism;
        depth = sel3 ? 8 : 4;
        exp_ones = 0;
        exp_mism = 0;
        for (int m = 0; m < depth; m++) begin
            exp_ones += int'(tbl[m]);
            if (tbl[m] != ex[m]) exp_mism++;
        end
        use3 = sel3;
        tt_in = tbl; exp_in = ex;
        if (sel3) begin start3 = 1'b1; load3 = with_load; end
        else      begin start2 = 1'b1; load2 = with_load; end
        step();
        start2 = 1'b0; start3 = 1'b0; load2 = 1'b0; load3 = 1'b0;
        chk("busy_at_start", 32'(ob), 32'd0);
        chk("ones_cleared", 32'(oo), 32'd0);
        for (int m = 0; m < depth; m++) begin
            if (m == inject_at) begin
                tt_in = ~tbl; exp_in = ~ex;
                if (sel3) begin start3 = 1'b1; load3 = 1'b1; end
                else      begin start2 = 1'b1; load2 = 1'b1; end
            end
            step();
            start2 = 1'b0; start3 = 1'b0; load2 = 1'b0; load3 = 1'b0;
            tt_in = tbl; exp_in = ex;
            chk("sweep_valid", 32'(ov), 32'd1);
            chk("sweep_m", 32'(om), 32'(m));
            chk("sweep_s", 32'(os), 32'(tbl[m]));
            chk("busy_sweep", {ob, od}, 32'd2);
        end
        step();
        chk("done_pulse", {od, ob, ov, os}, 32'b1100);
        chk("done_m", 32'(om), 32'd0);
        chk("ones_done", 32'(oo), 32'(exp_ones));
`ifdef TTS_CHECK_EN
        chk("mism_done", 32'(omm), 32'(exp_mism));
`endif
        step();
        chk("after_done", {od, ob, ov}, 32'd0);
        chk("ones_held", 32'(oo), 32'(exp_ones));
`ifdef TTS_CHECK_EN
        chk("mism_held", 32'(omm), 32'(exp_mism));
`endif
    endtask

    initial begin
        logic [7:0] tbl;
        logic [7:0] ex;
        rst_n = 1'b0;
        start2 = 1'b0; load2 = 1'b0; start3 = 1'b0; load3 = 1'b0;
        tt_in = '0; exp_in = '0; eval_x = '0; use3 = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Lookup path, including table-as-of-prior-edge behaviour.
        load(1'b0, 8'b1101, 8'h0);
        eval_chk(1'b0, 8'b1101, 3'd1);
        eval_chk(1'b0, 8'b1101, 3'd2);
        eval_chk(1'b0, 8'b1101, 3'd0);
        tt_in = 8'h0; load2 = 1'b1; eval_x = 3'd0;
        step();
        load2 = 1'b0;
        chk("eval_old_table", 32'(e2), 32'd1);
        step();
        chk("eval_new_table", 32'(e2), 32'd0);

        // XOR-style table with expected table differing at one minterm.
        load(1'b0, 8'b0110, 8'b0111);
        sweep(1'b0, 8'b0110, 8'b0111, -1, 1'b0);

        // Full and empty tables at depth 8.
        load(1'b1, 8'hFF, 8'hFF);
        sweep(1'b1, 8'hFF, 8'hFF, -1, 1'b0);
        load(1'b1, 8'h00, 8'h5A);
        sweep(1'b1, 8'h00, 8'h5A, -1, 1'b0);

        // Commands while busy are ignored; load with start uses the new table.
        sweep(1'b0, 8'b1010, 8'b0011, 1, 1'b1);
        sweep(1'b1, 8'h96, 8'h69, 5, 1'b1);
        eval_chk(1'b1, 8'h96, 3'd7);
        eval_chk(1'b1, 8'h96, 3'd1);

        // Randomized tables, lookups and sweeps.
        for (int it = 0; it < 12; it++) begin
            bit sel3;
            sel3 = it[0];
            tbl = 8'($urandom);
            ex  = 8'($urandom);
            if (!sel3) begin
                tbl[7:4] = '0;
                ex[7:4]  = '0;
            end
            if ($urandom_range(0, 1) == 0) begin
                load(sel3, tbl, ex);
                sweep(sel3, tbl, ex, int'($urandom_range(0, 9)), 1'b0);
            end else begin
                sweep(sel3, tbl, ex, int'($urandom_range(0, 9)), 1'b1);
            end
            for (int k = 0; k < 3; k++) begin
                logic [2:0] x;
                x = 3'($urandom_range(0, sel3 ? 7 : 3));
                eval_chk(sel3, tbl, x);
            end
        end

        // Reset mid-sweep aborts at once and clears the table.
        use3 = 1'b0;
        tt_in = 8'b0110; load2 = 1'b1; start2 = 1'b1;
        step();
        load2 = 1'b0; start2 = 1'b0;
        step();
        step();
        chk("pre_reset_m", 32'(m2), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("no_restart", {v2, d2, b2}, 32'd0);
        end
        for (int x = 0; x < 4; x++) eval_chk(1'b0, 8'h00, 3'(x));
        sweep(1'b0, 8'h00, 8'h00, -1, 1'b0);
        sweep(1'b0, 8'b1001, 8'b1111, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
